instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 89 ++++++++
 tb/tb_instruction_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: holds the PC and runs one memory request per fetch pulse.
// Decode sees the fetched word and its PC one cycle after the memory acknowledges.
module instruction_fetch #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            phase_fetch,
  input  logic            phase_writeback,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic            stall_fetch
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e          state_q;
  logic            req_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] cpc_q;

  // Next PC is also the address a same-cycle fetch uses.
  always_comb begin
    pc_d = pc_q;
    if (phase_writeback) begin
      if (jump_en) pc_d = {jump_addr[XLEN-1:2], 2'b00};
      else         pc_d = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_VECTOR;
      inst_q  <= NOP;
      cpc_q   <= RESET_VECTOR;
    end else begin
      case (state_q)
        IDLE: begin
          if (phase_fetch) begin
            state_q <= BUSY;
            req_q   <= 1'b1;
            addr_q  <= pc_d;
          end
        end
        BUSY: begin
          if (imem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            inst_q  <= imem_rdata;
            cpc_q   <= addr_q;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst        = inst_q;
  assign curr_pc_fd  = cpc_q;
  // Stall the sequencer already in the cycle the fetch pulse arrives.
  assign stall_fetch = req_q | ((state_q == IDLE) & phase_fetch);

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch: the driver models the PC and
// fetch rules and queues expectations; a negedge monitor pops and compares.
module tb_instruction_fetch;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        phase_fetch = 1'b0, phase_writeback = 1'b0, jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] curr_pc_fd;
  logic        stall_fetch;

  instruction_fetch #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n),
    .phase_fetch(phase_fetch), .phase_writeback(phase_writeback),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .curr_pc_fd(curr_pc_fd), .stall_fetch(stall_fetch)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic req; logic stall; } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  int nvec = 0;
  int nerr = 0;
  bit run = 0;

  // Reference model state
  logic [31:0] m_pc = RV;
  logic [31:0] m_addr = RV;
  bit          m_busy = 0;
  bit          started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: got unexpected event, expected none", nm);
  endtask

  // One cycle of stimulus plus the model's view of what it should cause.
  task automatic cyc(input logic pf, input logic pw, input logic je, input logic [31:0] ja,
                     input logic ack, input logic [31:0] rd);
    cyc_t e;
    bit   busy0;
    @(posedge clk); #1;
    phase_fetch = pf; phase_writeback = pw; jump_en = je; jump_addr = ja;
    imem_ack = ack; imem_rdata = rd;
    busy0   = m_busy;
    e.req   = busy0;
    e.stall = busy0 | pf;
    cyc_q.push_back(e);
    if (busy0 && ack) begin
      exp_inst_q.push_back({rd, m_addr});
      m_busy = 0;
    end
    if (pw) m_pc = je ? (ja & 32'hFFFF_FFFC) : m_pc + 32'd4;
    if (pf && !busy0) begin
      m_addr = m_pc;
      exp_addr_q.push_back(m_pc);
      m_busy  = 1;
      started = 1;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    phase_fetch = 1'b0; phase_writeback = 1'b0; jump_en = 1'b0; imem_ack = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_stall", 32'(stall_fetch), 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_curr_pc_fd", curr_pc_fd, RV);
    chk("rst_imem_addr", imem_addr, RV);
    cyc_q.delete(); exp_addr_q.delete(); exp_inst_q.delete();
    m_busy = 0; m_pc = RV; m_addr = RV;
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor
  bit          mon_prev_req = 0;
  bit          mon_pend = 0;
  logic [31:0] mon_inst = NOP;
  logic [31:0] mon_pc = RV;
  logic [31:0] mon_addr = RV;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_req = 0; mon_pend = 0;
      mon_inst = NOP; mon_pc = RV; mon_addr = RV;
    end else if (run) begin
      if (mon_pend) begin
        if (exp_inst_q.size() > 0) {mon_inst, mon_pc} = exp_inst_q.pop_front();
        else fail("inst_update_unexpected");
        mon_pend = 0;
      end
      chk("inst", inst, mon_inst);
      chk("curr_pc_fd", curr_pc_fd, mon_pc);
      if (cyc_q.size() == 0) fail("cycle_unexpected");
      else begin
        cyc_t e;
        e = cyc_q.pop_front();
        chk("imem_req", 32'(imem_req), 32'(e.req));
        chk("stall_fetch", 32'(stall_fetch), 32'(e.stall));
      end
      if (imem_req && !mon_prev_req) begin
        if (exp_addr_q.size() > 0) begin
          mon_addr = exp_addr_q.pop_front();
          chk("imem_addr", imem_addr, mon_addr);
        end else fail("request_unexpected");
      end else if (imem_req) begin
        chk("imem_addr_stable", imem_addr, mon_addr);
      end
      mon_pend     = imem_req && imem_ack;
      mon_prev_req = imem_req;
    end
  end

  initial begin
    int wt;
    logic pf, pw, je, ack;
    logic [31:0] ja;
    wt = 0;

    do_reset();
    run = 1;

    // Basic fetch, ack next cycle
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
    idle(); idle();

    // Ack delayed 3 cycles, second fetch pulse during the wait ignored
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    idle();

    // Jump masks low bits
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    idle();

    // Sequential wrap with writeback and fetch in the same cycle
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
    idle();

    // Writeback while busy keeps the latched address
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0BAD_0001);
    idle();

    // Reset mid-fetch, stale ack ignored, restart from reset vector
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_7777);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_1111);
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      pf = ($urandom_range(0, 2) == 0);
      pw = ($urandom_range(0, 3) == 0);
      je = 1'($urandom_range(0, 1));
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      if (m_busy) begin
        ack = (wt == 0);
        if (!ack) wt--;
      end else begin
        ack = ($urandom_range(0, 5) == 0);
      end
      started = 0;
      cyc(pf, pw, je, ja, ack, $urandom);
      if (started) wt = $urandom_range(0, 3);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    // Drain
    for (int i = 0; i < 8 && m_busy; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    idle(); idle();
    @(negedge clk); #1;
    chk("drain_cycles", cyc_q.size(), 32'd0);
    chk("drain_addrs", exp_addr_q.size(), 32'd0);
    chk("drain_insts", exp_inst_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
